// File: rtl/mac_accum_4bit.sv
// ============================================================================
// Module   : mac_accum_4bit
// Brief    : Multiply-accumulate back end. Sums N_TERMS 8-bit products taken
//            over a valid/ready input and offers the sum over a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accum_4bit #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       prod_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       term_count,
    output logic             overflow
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;

    localparam logic [7:0] C_N_TERMS = N_TERMS[7:0];

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q;

    logic             w_accept;
    logic [7:0]       w_cnt_inc;
    logic [ACC_W:0]   w_sum;

    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = cnt_q + 8'd1;
    // One extra bit so the carry-out flags the wrap into the sticky overflow.
    assign w_sum     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // clear outranks both drain and accept.
        if (clear || (state_q == DONE && out_ready)) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = 8'd0;
            ovf_d   = 1'b0;
        end else if (w_accept) begin
            acc_d = w_sum[ACC_W-1:0];
            cnt_d = w_cnt_inc;
            ovf_d = ovf_q | w_sum[ACC_W];
            if (w_cnt_inc == C_N_TERMS) begin
                state_d = DONE;
            end
        end
    end

    always_comb begin
        in_ready = (state_q == ACCUM) && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    assign acc_out    = acc_q;
    assign term_count = cnt_q;
    assign overflow   = ovf_q;
    assign out_valid  = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_accum_4bit.sv
// ============================================================================
// Module   : tb_mac_accum_4bit
// Brief    : Self-checking bench for mac_accum_4bit, default and 8-bit widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accum_4bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  prod_in;
    logic        in_valid;
    logic        clear;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, overflow_a;
    logic [11:0] acc_out_a;
    logic [7:0]  term_count_a;

    logic        in_ready_b, out_valid_b, overflow_b;
    logic [7:0]  acc_out_b;
    logic [7:0]  term_count_b;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: true (unbounded) running sum, terms taken, and done flag.
    int m_sum  = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    mac_accum_4bit #(.N_TERMS(4), .ACC_W(12)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .prod_in    (prod_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .clear      (clear),
        .acc_out    (acc_out_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .term_count (term_count_a),
        .overflow   (overflow_a)
    );

    mac_accum_4bit #(.N_TERMS(4), .ACC_W(8)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .prod_in    (prod_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .clear      (clear),
        .acc_out    (acc_out_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .term_count (term_count_b),
        .overflow   (overflow_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_clear();
        m_sum  = 0;
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    task automatic check_all();
        check("a.in_ready",   32'(in_ready_a),   32'(!m_done && !reset));
        check("a.out_valid",  32'(out_valid_a),  32'(m_done));
        check("a.acc_out",    32'(acc_out_a),    32'(m_sum % 4096));
        check("a.term_count", 32'(term_count_a), 32'(m_cnt));
        check("a.overflow",   32'(overflow_a),   32'(m_sum >= 4096));
        check("b.in_ready",   32'(in_ready_b),   32'(!m_done && !reset));
        check("b.out_valid",  32'(out_valid_b),  32'(m_done));
        check("b.acc_out",    32'(acc_out_b),    32'(m_sum % 256));
        check("b.term_count", 32'(term_count_b), 32'(m_cnt));
        check("b.overflow",   32'(overflow_b),   32'(m_sum >= 256));
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, then compare shortly after.
    task automatic step(input int p, input bit v, input bit ordy, input bit clr);
        @(negedge clk);
        prod_in   = 8'(p);
        in_valid  = v;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        if (clr || (m_done && ordy)) begin
            model_clear();
        end else if (v && !m_done) begin
            m_sum += p;
            m_cnt += 1;
            if (m_cnt == 4) m_done = 1'b1;
        end
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; prod_in = 8'd0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready",  32'(in_ready_a),  32'd0);
        check("rst.out_valid", 32'(out_valid_a), 32'd0);
        check("rst.acc_out",   32'(acc_out_a),   32'd0);
        reset = 1'b0;
        #1;
        check("rst.release_in_ready", 32'(in_ready_a), 32'd1);

        // Asynchronous reset mid-cycle after two accepts.
        step(50, 1, 0, 0);
        step(60, 1, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst.acc_out",    32'(acc_out_a),    32'd0);
        check("arst.term_count", 32'(term_count_a), 32'd0);
        check("arst.out_valid",  32'(out_valid_a),  32'd0);
        check("arst.in_ready",   32'(in_ready_a),   32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst.release", 32'(in_ready_a), 32'd1);

        // Back-to-back products, downstream always ready.
        step(117, 1, 1, 0);
        step(120, 1, 1, 0);
        step(100, 1, 1, 0);
        step(21,  1, 1, 0);
        check("seq.acc358", 32'(acc_out_a), 32'd358);
        check("seq.valid",  32'(out_valid_a), 32'd1);
        step(0, 0, 1, 0);
        check("seq.drained", 32'(acc_out_a), 32'd0);
        check("seq.ready",   32'(in_ready_a), 32'd1);

        // Backpressure: inputs while DONE must be ignored.
        for (int i = 0; i < 4; i++) step(225, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(64, 1, 0, 0);
        check("bp.acc900", 32'(acc_out_a), 32'd900);
        step(64, 1, 1, 0);
        step(64, 1, 0, 0);
        check("bp.acc64", 32'(acc_out_a), 32'd64);
        step(0, 1, 0, 1);

        // Gapped input.
        step(56, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(36, 1, 0, 0);
        step(0, 0, 0, 0);
        step(30, 1, 0, 0);
        step(35, 1, 0, 0);
        check("gap.acc157", 32'(acc_out_a), 32'd157);
        check("gap.count4", 32'(term_count_a), 32'd4);
        step(0, 0, 1, 0);

        // clear beats a simultaneous accept.
        step(49, 1, 0, 0);
        step(25, 1, 0, 0);
        step(100, 1, 0, 1);
        check("clr.acc0", 32'(acc_out_a), 32'd0);
        step(10, 1, 0, 0);
        step(20, 1, 0, 0);
        step(30, 1, 0, 0);
        step(40, 1, 0, 0);
        check("clr.acc100", 32'(acc_out_a), 32'd100);
        step(0, 0, 1, 0);

        // 8-bit accumulator wrap and sticky overflow.
        step(225, 1, 0, 0);
        step(225, 1, 0, 0);
        check("ovf.acc194", 32'(acc_out_b), 32'd194);
        check("ovf.flag",   32'(overflow_b), 32'd1);
        step(1, 1, 0, 0);
        step(2, 1, 0, 0);
        check("ovf.sticky", 32'(overflow_b), 32'd1);
        step(0, 0, 1, 0);
        check("ovf.drained", 32'(overflow_b), 32'd0);

        // Randomized traffic including clear during DONE with out_ready.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
